// File: rtl/shift_deserializer.sv
// Serial-to-parallel receive stage: assembles N-bit words (LSB- or MSB-first) into a valid/ready holding register.
// Optional even-parity frame checking is enabled by defining PARITY_CHK_EN (adds the ParityErr output).
module shift_deserializer #(
    parameter  int unsigned N     = 8,
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             SerIn,
    input  logic             SerValid,
    input  logic             Dir,
    input  logic             Clear,
    output logic [N-1:0]     Out,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy,
    output logic [CNT_W-1:0] BitCnt,
    output logic             Overrun
`ifdef PARITY_CHK_EN
    ,
    output logic             ParityErr
`endif
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

`ifdef PARITY_CHK_EN
    // The parity bit arrives when N data bits are already held, so the count runs up to N.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_sreg;
    logic [N-1:0]     w_sreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [N-1:0]     r_out;
    logic [N-1:0]     w_out_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             r_overrun;
    logic             w_overrun_nxt;

    logic             w_accept;
    logic             w_last;
    logic             w_dir_eff;
    logic [N-1:0]     w_shifted;
    logic [N-1:0]     w_word;

`ifdef PARITY_CHK_EN
    logic             r_perr;
    logic             w_perr_nxt;
    logic             w_word_perr;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_CHK_EN
            r_perr      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_overrun   <= w_overrun_nxt;
`ifdef PARITY_CHK_EN
            r_perr      <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_dir_nxt       = r_dir;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_overrun_nxt   = r_overrun;

        // Clear wins over a same-cycle serial bit, which is then discarded.
        w_accept  = SerValid && !Clear;
        w_last    = w_accept && (r_cnt == LAST_CNT);
        w_dir_eff = (r_state == S_IDLE) ? Dir : r_dir;
        w_shifted = w_dir_eff ? {r_sreg[N-2:0], SerIn} : {SerIn, r_sreg[N-1:1]};

`ifdef PARITY_CHK_EN
        w_perr_nxt  = r_perr;
        w_word      = r_sreg;
        w_word_perr = ^{r_sreg, SerIn};
`else
        w_word      = w_shifted;
`endif

        if (Clear) begin
            w_sreg_nxt    = '0;
            w_cnt_nxt     = '0;
            w_state_nxt   = S_IDLE;
            w_overrun_nxt = 1'b0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) begin
                w_dir_nxt = Dir;
            end
`ifdef PARITY_CHK_EN
            if (!w_last) begin
                w_sreg_nxt = w_shifted;
            end
`else
            w_sreg_nxt = w_shifted;
`endif
            if (w_last) begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end else begin
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                w_state_nxt = S_COLLECT;
            end
        end

        // A completing word loads the holding register if it is free or being read this cycle.
        if (w_last) begin
            if (!r_out_valid || OutReady) begin
                w_out_nxt       = w_word;
                w_out_valid_nxt = 1'b1;
`ifdef PARITY_CHK_EN
                w_perr_nxt      = w_word_perr;
`endif
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end else if (r_out_valid && OutReady) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    assign Out      = r_out;
    assign OutValid = r_out_valid;
    assign Busy     = (r_state == S_COLLECT);
    assign BitCnt   = r_cnt;
    assign Overrun  = r_overrun;
`ifdef PARITY_CHK_EN
    assign ParityErr = r_perr;
`endif

endmodule
